// File: rtl/hw1_phase_sequencer.sv
// rtl/hw1_phase_sequencer.sv - drives d/c/s of the address stage through four
// {c,s} phases and captures the stage's address at the end of each phase.
module hw1_phase_sequencer #(
   parameter int WIDTH = 16,
   parameter int HOLD  = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] req_in,
   input  logic [WIDTH-1:0] addr_in,
   output logic [WIDTH-1:0] d_out,
   output logic             c_out,
   output logic             s_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_p0,
   output logic [WIDTH-1:0] res_p1,
   output logic [WIDTH-1:0] res_p2,
   output logic [WIDTH-1:0] res_p3
);

   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       phase, phase_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] d_nx;
   logic             c_nx, s_nx, busy_nx, done_nx;
   logic [WIDTH-1:0] res    [4];
   logic [WIDTH-1:0] res_nx [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         phase <= 2'd0;
         cnt   <= '0;
         d_out <= '0;
         c_out <= 1'b0;
         s_out <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int i = 0; i < 4; i++) res[i] <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         cnt   <= cnt_nx;
         d_out <= d_nx;
         c_out <= c_nx;
         s_out <= s_nx;
         busy  <= busy_nx;
         done  <= done_nx;
         for (int i = 0; i < 4; i++) res[i] <= res_nx[i];
      end
   end

   // Control outputs are computed from the next state so the flops present
   // them in the same cycle the new phase begins.
   always_comb begin
      state_nx = state;
      phase_nx = phase;
      cnt_nx   = cnt;
      d_nx     = d_out;
      c_nx     = 1'b0;
      s_nx     = 1'b0;
      busy_nx  = busy;
      done_nx  = 1'b0;
      for (int i = 0; i < 4; i++) res_nx[i] = res[i];

      case (state)
         ST_IDLE: begin
            busy_nx = 1'b0;
            if (start) begin
               d_nx     = req_in;
               phase_nx = 2'd0;
               cnt_nx   = '0;
               busy_nx  = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_nx = 1'b1;
            if (cnt == LAST) begin
               res_nx[phase] = addr_in;
               cnt_nx        = '0;
               if (phase == 2'd3) begin
                  state_nx = ST_DONE;
                  done_nx  = 1'b1;
               end else begin
                  phase_nx = phase + 2'd1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ST_DONE: begin
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
         end
         default: begin
            busy_nx  = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase

      if (state_nx == ST_RUN) begin
         c_nx = phase_nx[0];
         s_nx = phase_nx[1];
      end
   end

   assign res_p0 = res[0];
   assign res_p1 = res[1];
   assign res_p2 = res[2];
   assign res_p3 = res[3];

endmodule

// File: tb/tb_hw1_phase_sequencer.sv
// tb/tb_hw1_phase_sequencer.sv - bench for hw1_phase_sequencer; HOLD=4 and
// HOLD=2 instances share stimulus and are each tracked by an index-based model.
module tb_hw1_phase_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic [15:0] req   = '0;
   logic [15:0] addr  = '0;

   logic [15:0] d4_d, d4_r0, d4_r1, d4_r2, d4_r3;
   logic        d4_c, d4_s, d4_busy, d4_done;
   logic [15:0] d2_d, d2_r0, d2_r1, d2_r2, d2_r3;
   logic        d2_c, d2_s, d2_busy, d2_done;

   hw1_phase_sequencer #(.WIDTH(16), .HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .req_in(req), .addr_in(addr),
      .d_out(d4_d), .c_out(d4_c), .s_out(d4_s), .busy(d4_busy), .done(d4_done),
      .res_p0(d4_r0), .res_p1(d4_r1), .res_p2(d4_r2), .res_p3(d4_r3));

   hw1_phase_sequencer #(.WIDTH(16), .HOLD(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .req_in(req), .addr_in(addr),
      .d_out(d2_d), .c_out(d2_c), .s_out(d2_s), .busy(d2_busy), .done(d2_done),
      .res_p0(d2_r0), .res_p1(d2_r1), .res_p2(d2_r2), .res_p3(d2_r3));

   // mode: 0 idle, 1 running (k = cycles since accept), 2 done cycle
   typedef struct {
      int          mode;
      int          k;
      logic [15:0] d;
      logic [15:0] res [4];
   } model_t;

   model_t m4, m2;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic void step(inout model_t m, input int h);
      if (rst) begin
         m.mode = 0;
         m.k    = 0;
         m.d    = '0;
         for (int i = 0; i < 4; i++) m.res[i] = '0;
      end else if (m.mode == 0) begin
         if (start) begin
            m.d    = req;
            m.k    = 0;
            m.mode = 1;
         end
      end else if (m.mode == 1) begin
         if (m.k % h == h - 1) m.res[m.k / h] = addr;
         m.k++;
         if (m.k == 4 * h) m.mode = 2;
      end else begin
         m.mode = 0;
      end
   endfunction

   function automatic logic [3:0] ctl(input model_t m, input int h);
      int ph;
      ph = m.k / h;
      if (m.mode == 1) return {ph[0], ph[1], 1'b1, 1'b0};
      if (m.mode == 2) return 4'b0011;
      return 4'b0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      step(m4, 4);
      step(m2, 2);
      #1;
      check("ctl_h4", {60'd0, d4_c, d4_s, d4_busy, d4_done}, {60'd0, ctl(m4, 4)});
      check("d_h4",   {48'd0, d4_d}, {48'd0, m4.d});
      check("res_h4", {d4_r0, d4_r1, d4_r2, d4_r3}, {m4.res[0], m4.res[1], m4.res[2], m4.res[3]});
      check("ctl_h2", {60'd0, d2_c, d2_s, d2_busy, d2_done}, {60'd0, ctl(m2, 2)});
      check("d_h2",   {48'd0, d2_d}, {48'd0, m2.d});
      check("res_h2", {d2_r0, d2_r1, d2_r2, d2_r3}, {m2.res[0], m2.res[1], m2.res[2], m2.res[3]});
      addr = 16'($urandom);
   endtask

   initial begin
      int first4, first2, ndone4, dd;

      // reset
      rst = 1'b1;
      tick();
      tick();
      check("reset_busy_done", {62'd0, d4_busy, d4_done}, 64'd0);
      rst = 1'b0;
      tick();

      // basic run with an ignored start during phase 2
      req   = 16'hFFFE;
      start = 1'b1;
      tick();
      first4 = 0;
      first2 = 0;
      ndone4 = 0;
      for (int i = 1; i <= 24; i++) begin
         if (i == 9) begin
            start = 1'b1;
            req   = 16'h0001;
         end else begin
            start = 1'b0;
         end
         tick();
         if (d4_done) begin
            ndone4++;
            if (first4 == 0) first4 = i;
         end
         if (d2_done && first2 == 0) first2 = i;
         if (i == 10) check("ignored_start_d", {48'd0, d4_d}, {48'd0, 16'hFFFE});
      end
      check("done_latency_h4", 64'(first4), 64'd16);
      check("done_latency_h2", 64'(first2), 64'd8);
      check("done_count_h4", 64'(ndone4), 64'd1);

      // abort in the 2nd cycle of phase 1
      req   = 16'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_state", {59'd0, d4_c, d4_s, d4_busy, d4_done, 1'b0}, 64'd0);
      check("abort_res0", {48'd0, d4_r0}, 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // back-to-back with start held high
      req   = 16'h8000;
      start = 1'b1;
      dd    = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) req = 16'h00FF;
         tick();
         if (dd < 0 && d4_done) dd = i;
         if (dd >= 0 && i == dd + 1) check("b2b_idle_gap", {63'd0, d4_busy}, 64'd0);
         if (dd >= 0 && i == dd + 2) check("b2b_second_d", {48'd0, d4_d}, {48'd0, 16'h00FF});
      end
      check("b2b_done_seen", {63'd0, dd > 0}, 64'd1);
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         start = ($urandom % 6) == 0;
         req   = 16'($urandom);
         rst   = ($urandom % 60) == 0;
         tick();
      end
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
